// File: rtl/my_package.sv
// rtl/my_package.sv - shared ROB record type and constants
package my_package;

  typedef struct packed {
    logic [6:0]  rd_opcode;
    logic [31:0] rd_value;
    logic [31:0] rs2_value;
    logic [5:0]  curr_d_reg;
    logic [5:0]  old_d_reg;
  } rob_entry;

  localparam logic [6:0] STORE_OPCODE = 7'b0100011;
  localparam int ROB_DEPTH = 16;

endpackage

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrap-bit circular pointer with +0/+1/+2 increment
module rob_ptr #(
  parameter int IDX_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     inc,
  output logic [IDX_W:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr + (IDX_W+1)'(inc);
  end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit buffer, 2 allocs / 2 completions / 2 retires per cycle
module reorder_buffer
  import my_package::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alloc_valid,
  input  rob_entry         alloc_entry_1,
  input  rob_entry         alloc_entry_2,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx_1,
  output logic [IDX_W-1:0] alloc_idx_2,
  input  logic [1:0]       cmpl_valid,
  input  logic [IDX_W-1:0] cmpl_idx_1,
  input  logic [IDX_W-1:0] cmpl_idx_2,
  input  logic [31:0]      cmpl_rd_value_1,
  input  logic [31:0]      cmpl_rd_value_2,
  input  logic [31:0]      cmpl_rs2_value_1,
  input  logic [31:0]      cmpl_rs2_value_2,
  output rob_entry         rob_o_1,
  output rob_entry         rob_o_2,
  output logic [1:0]       num_retired,
  output logic [IDX_W:0]   rob_count
);

  localparam logic [IDX_W:0] DEPTH_P = (IDX_W+1)'(DEPTH);

  logic [IDX_W:0]   head, tail, occ;
  logic [IDX_W-1:0] head_idx, head_idx2, tail_idx, tail_idx2;
  logic [DEPTH-1:0] valid, done;
  rob_entry         mem [DEPTH];
  logic [1:0]       n, alloc_n;
  logic             cmpl_ok_1, cmpl_ok_2;

  rob_ptr #(.IDX_W(IDX_W)) u_head (.clk(clk), .reset(reset), .inc(n),       .ptr(head));
  rob_ptr #(.IDX_W(IDX_W)) u_tail (.clk(clk), .reset(reset), .inc(alloc_n), .ptr(tail));

  assign head_idx  = head[IDX_W-1:0];
  assign head_idx2 = head[IDX_W-1:0] + IDX_W'(1);
  assign tail_idx  = tail[IDX_W-1:0];
  assign tail_idx2 = tail[IDX_W-1:0] + IDX_W'(1);

  // Pointer-only paths keep these outputs free of any input dependency
  assign occ         = tail - head;
  assign alloc_ready = (DEPTH_P - occ) >= (IDX_W+1)'(2);
  assign alloc_idx_1 = tail_idx;
  assign alloc_idx_2 = tail_idx2;

  assign alloc_n   = (alloc_valid[0] && alloc_ready) ? (alloc_valid[1] ? 2'd2 : 2'd1) : 2'd0;
  assign cmpl_ok_1 = cmpl_valid[0] && valid[cmpl_idx_1];
  assign cmpl_ok_2 = cmpl_valid[1] && valid[cmpl_idx_2];

  always_comb begin
    n = 2'd0;
    if (valid[head_idx] && done[head_idx]) begin
      n = 2'd1;
      if (valid[head_idx2] && done[head_idx2]) n = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= '0;
      done        <= '0;
      rob_o_1     <= '0;
      rob_o_2     <= '0;
      num_retired <= 2'd0;
      rob_count   <= '0;
    end else begin
      rob_o_1     <= (n != 2'd0) ? mem[head_idx]  : '0;
      rob_o_2     <= (n == 2'd2) ? mem[head_idx2] : '0;
      num_retired <= n;
      rob_count   <= rob_count + (IDX_W+1)'(alloc_n) - (IDX_W+1)'(n);
      if (n != 2'd0) begin
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
      end
      if (n == 2'd2) begin
        valid[head_idx2] <= 1'b0;
        done[head_idx2]  <= 1'b0;
      end
      if (alloc_n != 2'd0) begin
        valid[tail_idx] <= 1'b1;
        done[tail_idx]  <= 1'b0;
      end
      if (alloc_n == 2'd2) begin
        valid[tail_idx2] <= 1'b1;
        done[tail_idx2]  <= 1'b0;
      end
      if (cmpl_ok_1) done[cmpl_idx_1] <= 1'b1;
      if (cmpl_ok_2) done[cmpl_idx_2] <= 1'b1;
    end
  end

  // Payload needs no reset: an entry is only read once valid and done
  always_ff @(posedge clk) begin
    if (alloc_n != 2'd0) mem[tail_idx]  <= alloc_entry_1;
    if (alloc_n == 2'd2) mem[tail_idx2] <= alloc_entry_2;
    if (cmpl_ok_1) begin
      mem[cmpl_idx_1].rd_value  <= cmpl_rd_value_1;
      mem[cmpl_idx_1].rs2_value <= cmpl_rs2_value_1;
    end
    if (cmpl_ok_2) begin
      mem[cmpl_idx_2].rd_value  <= cmpl_rd_value_2;
      mem[cmpl_idx_2].rs2_value <= cmpl_rs2_value_2;
    end
  end

  a_alloc_legal: assert property (@(posedge clk) disable iff (reset) alloc_valid != 2'b10);
  a_cmpl_1_retire: assert property (@(posedge clk) disable iff (reset)
    !(cmpl_valid[0] && ((n != 2'd0 && cmpl_idx_1 == head_idx) || (n == 2'd2 && cmpl_idx_1 == head_idx2))));
  a_cmpl_2_retire: assert property (@(posedge clk) disable iff (reset)
    !(cmpl_valid[1] && ((n != 2'd0 && cmpl_idx_2 == head_idx) || (n == 2'd2 && cmpl_idx_2 == head_idx2))));

endmodule
